// File: rtl/half_adder.sv
// Multi-lane half adder with optional output register and a saturating
// counter of valid cycles that produced a carry in any lane.
module half_adder #(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic             any_carry,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: per-lane combinational sum/carry, no inter-lane propagation
  logic [WIDTH-1:0] sum_p0;
  logic [WIDTH-1:0] carry_p0;
  logic             carry_evt_p0;

  assign sum_p0       = X ^ Y;
  assign carry_p0     = X & Y;
  assign carry_evt_p0 = in_valid && (|carry_p0);

  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (cnt_clr) begin
      cnt_p1 <= '0;
    end else if (carry_evt_p0) begin
      cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign carry_cnt = cnt_p1;

  // Stage p1: optional output register; results hold while in_valid is low
  generate
    if (REGISTERED != 0) begin : g_reg
      logic [WIDTH-1:0] sum_p1;
      logic [WIDTH-1:0] carry_p1;
      logic             vld_p1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_p1   <= '0;
          carry_p1 <= '0;
          vld_p1   <= 1'b0;
        end else begin
          vld_p1 <= in_valid;
          if (in_valid) begin
            sum_p1   <= sum_p0;
            carry_p1 <= carry_p0;
          end
        end
      end

      assign s         = sum_p1;
      assign c         = carry_p1;
      assign out_valid = vld_p1;
    end else begin : g_comb
      assign s         = sum_p0;
      assign c         = carry_p0;
      assign out_valid = in_valid & rst_n;
    end
  endgenerate

  assign any_carry = |c;

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: registered WIDTH=1 and WIDTH=4 instances
// checked against a scoreboard model, plus a combinational instance.
module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       v1, clr1, ov1, ac1;
  logic [0:0] x1, y1, s1, c1;
  logic [15:0] cnt1;

  logic       v4, clr4, ov4, ac4;
  logic [3:0] x4, y4, s4, c4;
  logic [1:0] cnt4;

  logic       vc, clrc, ovc, acc;
  logic [0:0] xc, yc, sc, cc;
  logic [3:0] cntc;

  half_adder #(.WIDTH(1), .REGISTERED(1), .CNT_W(16)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .X(x1), .Y(y1), .cnt_clr(clr1),
    .s(s1), .c(c1), .out_valid(ov1), .any_carry(ac1), .carry_cnt(cnt1));

  half_adder #(.WIDTH(4), .REGISTERED(1), .CNT_W(2)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .X(x4), .Y(y4), .cnt_clr(clr4),
    .s(s4), .c(c4), .out_valid(ov4), .any_carry(ac4), .carry_cnt(cnt4));

  half_adder #(.WIDTH(1), .REGISTERED(0), .CNT_W(4)) dc (
    .clk(clk), .rst_n(rst_n), .in_valid(vc), .X(xc), .Y(yc), .cnt_clr(clrc),
    .s(sc), .c(cc), .out_valid(ovc), .any_carry(acc), .carry_cnt(cntc));

  typedef struct packed {
    logic [3:0]  s;
    logic [3:0]  c;
    logic        ov;
    logic        ac;
    logic [15:0] cnt;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  logic [3:0] m1_s, m1_c, m4_s, m4_c;
  int         m1_cnt, m4_cnt;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step1(input logic v, input logic x, input logic y, input logic clr,
                       input string tag);
    exp_t e;
    v1 = v; x1 = x; y1 = y; clr1 = clr;
    if (v) begin
      m1_s = {3'b0, x ^ y};
      m1_c = {3'b0, x & y};
    end
    if (clr) m1_cnt = 0;
    else if (v && (x & y) && m1_cnt < 65535) m1_cnt++;
    e.s = m1_s; e.c = m1_c; e.ov = v; e.ac = |m1_c; e.cnt = 16'(m1_cnt);
    q1.push_back(e);
    @(posedge clk); #1;
    e = q1.pop_front();
    chk({tag, ".s"},   32'(s1),   32'(e.s));
    chk({tag, ".c"},   32'(c1),   32'(e.c));
    chk({tag, ".ov"},  32'(ov1),  32'(e.ov));
    chk({tag, ".ac"},  32'(ac1),  32'(e.ac));
    chk({tag, ".cnt"}, 32'(cnt1), 32'(e.cnt));
    @(negedge clk);
  endtask

  task automatic step4(input logic v, input logic [3:0] x, input logic [3:0] y,
                       input logic clr, input string tag);
    exp_t e;
    v4 = v; x4 = x; y4 = y; clr4 = clr;
    if (v) begin
      m4_s = x ^ y;
      m4_c = x & y;
    end
    if (clr) m4_cnt = 0;
    else if (v && (x & y) != 4'b0 && m4_cnt < 3) m4_cnt++;
    e.s = m4_s; e.c = m4_c; e.ov = v; e.ac = |m4_c; e.cnt = 16'(m4_cnt);
    q4.push_back(e);
    @(posedge clk); #1;
    e = q4.pop_front();
    chk({tag, ".s"},   32'(s4),   32'(e.s));
    chk({tag, ".c"},   32'(c4),   32'(e.c));
    chk({tag, ".ov"},  32'(ov4),  32'(e.ov));
    chk({tag, ".ac"},  32'(ac4),  32'(e.ac));
    chk({tag, ".cnt"}, 32'(cnt4), 32'(e.cnt));
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".s1"},   32'(s1),   32'h0);
    chk({tag, ".c1"},   32'(c1),   32'h0);
    chk({tag, ".ov1"},  32'(ov1),  32'h0);
    chk({tag, ".ac1"},  32'(ac1),  32'h0);
    chk({tag, ".cnt1"}, 32'(cnt1), 32'h0);
    chk({tag, ".s4"},   32'(s4),   32'h0);
    chk({tag, ".c4"},   32'(c4),   32'h0);
    chk({tag, ".ov4"},  32'(ov4),  32'h0);
    chk({tag, ".ac4"},  32'(ac4),  32'h0);
    chk({tag, ".cnt4"}, 32'(cnt4), 32'h0);
    chk({tag, ".ovc"},  32'(ovc),  32'h0);
    chk({tag, ".cntc"}, 32'(cntc), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 0; x1 = 0; y1 = 0; clr1 = 0;
    v4 = 0; x4 = 0; y4 = 0; clr4 = 0;
    vc = 0; xc = 0; yc = 0; clrc = 0;
    m1_s = 0; m1_c = 0; m1_cnt = 0;
    m4_s = 0; m4_c = 0; m4_cnt = 0;

    @(negedge clk); @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // truth table, then hold with idle inputs
    step1(1, 0, 0, 0, "tt00");
    step1(1, 0, 1, 0, "tt01");
    step1(1, 1, 0, 0, "tt10");
    step1(1, 1, 1, 0, "tt11");
    step1(1, 1, 1, 0, "hold_a");
    step1(0, 0, 0, 0, "hold_b");

    // lanes, ignored invalid input, saturation, clear priority
    step4(1, 4'b1011, 4'b0110, 0, "lanes");
    step4(0, 4'b1111, 4'b1111, 0, "inv_ign");
    step4(1, 4'b1111, 4'b1111, 0, "multi");
    step4(1, 4'b1000, 4'b1100, 0, "car3");
    step4(1, 4'b0001, 4'b0001, 0, "sat4");
    step4(1, 4'b0100, 4'b0100, 0, "sat5");
    step4(1, 4'b1111, 4'b0001, 1, "clr_pri");
    step4(1, 4'b0101, 4'b1010, 0, "nocarry");

    // asynchronous reset between edges while d1 holds s,c = 0,1
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    m1_s = 0; m1_c = 0; m1_cnt = 0;
    m4_s = 0; m4_c = 0; m4_cnt = 0;
    @(posedge clk); #1;
    chk_all_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    step1(0, 1, 1, 0, "post_idle");
    step1(1, 1, 1, 0, "post_valid");

    // combinational instance
    vc = 1; xc = 0; yc = 0;
    #1;
    chk("comb00.s",  32'(sc),  32'h0);
    chk("comb00.c",  32'(cc),  32'h0);
    chk("comb00.ov", 32'(ovc), 32'h1);
    chk("comb00.ac", 32'(acc), 32'h0);
    #1 xc = 1; yc = 1;
    #1;
    chk("comb11.s",  32'(sc),  32'h0);
    chk("comb11.c",  32'(cc),  32'h1);
    chk("comb11.ov", 32'(ovc), 32'h1);
    chk("comb11.ac", 32'(acc), 32'h1);
    @(posedge clk); #1;
    chk("comb_cnt", 32'(cntc), 32'h1);
    @(negedge clk);
    vc = 0;
    #1 chk("comb_ov0", 32'(ovc), 32'h0);
    @(posedge clk); #1;
    chk("comb_cnt_inv", 32'(cntc), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1: number of independent half-adder bit lanes (1..64).
REQ-002 The block SHALL have parameter REGISTERED, default 1: 1 means outputs are registered, 0 means outputs are combinational.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of the carry-event counter.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; all sequential logic SHALL use clk and rst_n.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: X and Y are valid this cycle.
REQ-008 The block SHALL have port X, input, WIDTH bits: addend A, one bit per lane.
REQ-009 The block SHALL have port Y, input, WIDTH bits: addend B, one bit per lane.
REQ-010 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of carry_cnt.
REQ-011 The block SHALL have port s, output, WIDTH bits: per-lane sum.
REQ-012 The block SHALL have port c, output, WIDTH bits: per-lane carry.
REQ-013 The block SHALL have port out_valid, output, 1 bit: s and c are valid.
REQ-014 The block SHALL have port any_carry, output, 1 bit: OR-reduction of c.
REQ-015 The block SHALL have port carry_cnt, output, CNT_W bits: saturating count of valid cycles with any carry.

Function
REQ-016 For each lane i, the sum SHALL be X[i] XOR Y[i] and the carry SHALL be X[i] AND Y[i]; lanes SHALL be fully independent, with no carry propagation between lanes.
REQ-017 With REGISTERED=1, a rising clk edge with in_valid=1 SHALL load the results into s and c, giving 1-cycle latency.
REQ-018 With REGISTERED=1, out_valid SHALL be in_valid delayed by one cycle.
REQ-019 With REGISTERED=1, s and c SHALL hold their last values during cycles with in_valid=0.
REQ-020 With REGISTERED=0, s and c SHALL be purely combinational from X and Y, with zero latency, and out_valid SHALL equal in_valid.
REQ-021 any_carry SHALL always equal the OR of the c output as presented, in either mode.
REQ-022 carry_cnt SHALL increment by exactly 1 on each rising clk edge where in_valid=1 and (X AND Y) is nonzero in any lane; multiple carrying lanes in one cycle SHALL still count as 1.
REQ-023 carry_cnt SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-024 cnt_clr=1 SHALL set carry_cnt to 0 on the next rising edge and SHALL take priority over a simultaneous increment.
REQ-025 carry_cnt SHALL use the same timing in both REGISTERED modes.
REQ-026 X and Y values SHALL be ignored for counting whenever in_valid=0.
REQ-027 The block SHALL contain no combinational loops and no latches.

Reset
REQ-028 While rst_n=0, s, c, out_valid, any_carry and carry_cnt SHALL all be 0, asynchronously and regardless of clk; with REGISTERED=0, only out_valid and carry_cnt are forced to 0, and s and c remain combinational.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight registered result.
REQ-030 On the first rising edge after rst_n deasserts, the block SHALL process inputs normally.
REQ-031 rst_n deassertion SHALL be treated as synchronous to clk; synchronizing it is the system's responsibility.

Verification
REQ-032 Truth table, WIDTH=1, REGISTERED=1, in_valid=1: X,Y = 00, 01, 10, 11 on consecutive cycles -> one cycle later s,c = 0,0 / 1,0 / 1,0 / 0,1; any_carry=1 only for the 11 case; carry_cnt=1 afterwards.
REQ-033 Lanes, WIDTH=4: X=4'b1011, Y=4'b0110 -> s=4'b1101, c=4'b0010, any_carry=1, carry_cnt increments by exactly 1.
REQ-034 Hold: apply X=1, Y=1 valid, then in_valid=0 with X=0, Y=0 -> s,c remain 0,1, out_valid=0, carry_cnt unchanged.
REQ-035 Saturation/clear: CNT_W=2, drive 5 valid carrying cycles -> carry_cnt=3; then cnt_clr=1 in the same cycle as a carrying input -> carry_cnt=0.
REQ-036 Reset mid-stream: assert rst_n=0 between clock edges while s,c = 0,1 -> all outputs read 0 immediately, and stay 0 until a valid input arrives after release.
REQ-037 Combinational mode, REGISTERED=0: change X,Y from 00 to 11 -> s,c = 0,1 in the same cycle, with out_valid tracking in_valid.
